// File: rtl/lut_sched_pkg.sv
// Shared types and helpers for the LUT layer scheduler.
package lut_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // Neuron index width; a single-neuron layer still needs one index bit.
  function automatic int nidx_w(input int neurons);
    return (neurons <= 1) ? 1 : $clog2(neurons);
  endfunction

  // Even parity bit: XOR of all data bits, so data plus bit has even weight.
  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/lut_sched_ram.sv
// Simple dual-port truth-table RAM: one write port, one registered read port.
module lut_sched_ram #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately not reset so loaded tables survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed LogicNets layer: one shared LUT RAM, one neuron lookup per cycle.
// Optional LUT_PARITY_EN adds a stored even-parity bit, cfg_par_inv and sticky par_err.
module lut_layer_scheduler
  import lut_sched_pkg::*;
#(
  parameter int NEURONS = 32,
  parameter int ADDR_W  = 8,
  parameter int OUT_W   = 2,
  localparam int NIDX_W = nidx_w(NEURONS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NEURONS*ADDR_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NEURONS*OUT_W-1:0]  out_data,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [NIDX_W+ADDR_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0]          cfg_data,
`ifdef LUT_PARITY_EN
  input  logic                      cfg_par_inv,
  output logic                      par_err,
`endif
  output logic                      busy
);

`ifdef LUT_PARITY_EN
  localparam int RAM_W = OUT_W + 1;
`else
  localparam int RAM_W = OUT_W;
`endif
  localparam int AW    = NIDX_W + ADDR_W;
  localparam int DEPTH = NEURONS * (2 ** ADDR_W);
  localparam logic [NIDX_W-1:0] LAST_IDX = NIDX_W'(NEURONS - 1);

  sched_state_e              state;
  logic [NIDX_W-1:0]         idx;
  logic [NEURONS*ADDR_W-1:0] addr_reg;
  logic [AW-1:0]             rd_addr;
  logic [RAM_W-1:0]          wr_word;
  logic [RAM_W-1:0]          rd_q;
  logic                      wr_en;
  logic                      rd_en;

  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == IDLE) && !cfg_valid;
  assign busy      = (state != IDLE);
  assign wr_en     = cfg_valid && cfg_ready;
  assign rd_en     = (state == RUN);

`ifdef LUT_PARITY_EN
  assign wr_word = {even_par(32'(cfg_data)) ^ cfg_par_inv, cfg_data};
`else
  assign wr_word = cfg_data;
`endif

  always_comb begin
    rd_addr = {idx, addr_reg[int'(idx)*ADDR_W +: ADDR_W]};
  end

  lut_sched_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (RAM_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cfg_addr),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_q)
  );

  // RUN captures the read issued one cycle earlier into slice idx-1; DRAIN takes the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      addr_reg  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            addr_reg <= in_data;
            idx      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (idx != '0)
            out_data[(int'(idx) - 1)*OUT_W +: OUT_W] <= rd_q[OUT_W-1:0];
          if (idx == LAST_IDX) state <= DRAIN;
          else                 idx   <= idx + NIDX_W'(1);
        end
        DRAIN: begin
          out_data[int'(idx)*OUT_W +: OUT_W] <= rd_q[OUT_W-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LUT_PARITY_EN
  logic rd_chk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_chk  <= 1'b0;
      par_err <= 1'b0;
    end else begin
      rd_chk <= rd_en;
      if (rd_chk && (even_par(32'(rd_q[OUT_W-1:0])) != rd_q[OUT_W]))
        par_err <= 1'b1;
    end
  end
`endif

endmodule
